fpu_addsub_arbiter: RTL



---
 rtl/fpu_arb_pkg.sv | 24 ++
 rtl/fpu_res_fifo.sv | 52 +++++
 rtl/fpu_addsub_arbiter.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/fpu_arb_pkg.sv
// Shared definitions for the FP add/sub arbiter: opcodes, default sizes,
// lane identifiers and the tracking-slot record that follows each op
// through the shared unit's pipeline.
package fpu_arb_pkg;

    localparam logic OP_SUB = 1'b0;
    localparam logic OP_ADD = 1'b1;

    localparam int unsigned DEF_TAG_W  = 6;
    localparam int unsigned DEF_FU_LAT = 2;
    localparam int unsigned DEF_DEPTH  = DEF_FU_LAT + 1;

    typedef enum logic {
        LANE0 = 1'b0,
        LANE1 = 1'b1
    } lane_e;

    typedef struct packed {
        logic                 v;
        lane_e                lane;
        logic [DEF_TAG_W-1:0] tag;
    } trk_slot_t;

endpackage

// File: rtl/fpu_res_fifo.sv
// Per-lane result FIFO: first-word-fall-through, simultaneous push/pop,
// pointers wrap modulo DEPTH, occupancy exported as count.
module fpu_res_fifo #(
    parameter int unsigned W     = 38,
    parameter int unsigned DEPTH = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [W-1:0]               push_data,
    input  logic                       pop,
    output logic [W-1:0]               rd_data,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH+1);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH-1)) ? '0 : p + PW'(1);
    endfunction

    // Storage array; no reset needed because count gates visibility.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_next(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/fpu_addsub_arbiter.sv
// Shares one fixed-latency FP subtract unit between two issue lanes.
// Round-robin grant, add folded into sub by negating operand 2, a tracking
// shift register that follows the unit's pipeline, and credit-limited
// per-lane result FIFOs so a completing result always has room.
module fpu_addsub_arbiter
    import fpu_arb_pkg::*;
#(
    parameter int unsigned TAG_W  = DEF_TAG_W,
    parameter int unsigned FU_LAT = DEF_FU_LAT,
    parameter int unsigned DEPTH  = DEF_DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic             req0_op,
    input  logic [31:0]      req0_x1,
    input  logic [31:0]      req0_x2,
    input  logic [TAG_W-1:0] req0_tag,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic             req1_op,
    input  logic [31:0]      req1_x1,
    input  logic [31:0]      req1_x2,
    input  logic [TAG_W-1:0] req1_tag,
    output logic             res0_valid,
    input  logic             res0_ready,
    output logic [31:0]      res0_y,
    output logic [TAG_W-1:0] res0_tag,
    output logic             res1_valid,
    input  logic             res1_ready,
    output logic [31:0]      res1_y,
    output logic [TAG_W-1:0] res1_tag,
    output logic [31:0]      fu_x1,
    output logic [31:0]      fu_x2,
    input  logic [31:0]      fu_y
);
    localparam int unsigned CW = $clog2(DEPTH+1);

    logic [CW-1:0]    cred [2];
    lane_e            rr;
    logic             elig0, elig1, grant_any;
    lane_e            grant_lane;
    logic             sel_op;
    logic [31:0]      sel_x1, sel_x2;
    logic [TAG_W-1:0] sel_tag;
    logic [1:0]       acc, pop;
    trk_slot_t        trk [FU_LAT+1];
    logic             push0, push1;
    logic [CW-1:0]    cnt0, cnt1;

    // Eligibility, round-robin grant and payload select.
    always_comb begin
        elig0      = req0_valid && (cred[0] < CW'(DEPTH));
        elig1      = req1_valid && (cred[1] < CW'(DEPTH));
        grant_any  = !rst && (elig0 || elig1);
        grant_lane = LANE0;
        if (elig0 && elig1) begin
            grant_lane = (rr == LANE0) ? LANE1 : LANE0;
        end else if (elig1) begin
            grant_lane = LANE1;
        end
        req0_ready = grant_any && (grant_lane == LANE0);
        req1_ready = grant_any && (grant_lane == LANE1);
        sel_op  = req0_op;
        sel_x1  = req0_x1;
        sel_x2  = req0_x2;
        sel_tag = req0_tag;
        if (grant_lane == LANE1) begin
            sel_op  = req1_op;
            sel_x1  = req1_x1;
            sel_x2  = req1_x2;
            sel_tag = req1_tag;
        end
    end

    assign acc = {req1_ready, req0_ready};
    assign pop = {res1_valid && res1_ready, res0_valid && res0_ready};

    // Operand registers, round-robin pointer and the tracking pipeline.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr    <= LANE1;
            fu_x1 <= '0;
            fu_x2 <= '0;
            for (int unsigned i = 0; i <= FU_LAT; i++) begin
                trk[i] <= '0;
            end
        end else begin
            if (grant_any) begin
                rr    <= grant_lane;
                fu_x1 <= sel_x1;
                fu_x2 <= (sel_op == OP_ADD) ? {~sel_x2[31], sel_x2[30:0]} : sel_x2;
            end
            trk[0] <= '{v: grant_any, lane: grant_lane, tag: sel_tag};
            for (int unsigned i = 1; i <= FU_LAT; i++) begin
                trk[i] <= trk[i-1];
            end
        end
    end

    // Issue credits: ops issued and not yet popped, per lane.
    always_ff @(posedge clk) begin
        if (rst) begin
            cred[0] <= '0;
            cred[1] <= '0;
        end else begin
            for (int unsigned i = 0; i < 2; i++) begin
                cred[i] <= cred[i] + CW'(acc[i]) - CW'(pop[i]);
            end
        end
    end

    assign push0 = !rst && trk[FU_LAT].v && (trk[FU_LAT].lane == LANE0);
    assign push1 = !rst && trk[FU_LAT].v && (trk[FU_LAT].lane == LANE1);

    fpu_res_fifo #(.W(32 + TAG_W), .DEPTH(DEPTH)) u_fifo0 (
        .clk       (clk),
        .rst       (rst),
        .push      (push0),
        .push_data ({fu_y, trk[FU_LAT].tag}),
        .pop       (pop[0]),
        .rd_data   ({res0_y, res0_tag}),
        .count     (cnt0)
    );

    fpu_res_fifo #(.W(32 + TAG_W), .DEPTH(DEPTH)) u_fifo1 (
        .clk       (clk),
        .rst       (rst),
        .push      (push1),
        .push_data ({fu_y, trk[FU_LAT].tag}),
        .pop       (pop[1]),
        .rd_data   ({res1_y, res1_tag}),
        .count     (cnt1)
    );

    assign res0_valid = !rst && (cnt0 != '0);
    assign res1_valid = !rst && (cnt1 != '0);

endmodule
